// File: rtl/count_monitor_pkg.sv
// Shared types and default widths for the counter monitor slice.
package count_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        FAULT   = 2'd3
    } state_e;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_WRAP_W    = 8;
    localparam int DEF_ERRC_W    = 8;
    localparam int DEF_ERR_LIMIT = 3;

endpackage

// File: rtl/count_monitor_sat_counter.sv
// Saturating up-counter with async reset and synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Counter state: clear has priority, increment stops at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/count_monitor.sv
// Checks that sampled counter values step by +1 and latches a fault on
// repeated consecutive mismatches; also tracks wraps and total errors.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int WRAP_W    = DEF_WRAP_W,
    parameter int ERRC_W    = DEF_ERRC_W,
    parameter int ERR_LIMIT = DEF_ERR_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  q_in,
    input  logic              clr_err,
    output logic              locked,
    output logic              err,
    output logic              fault,
    output logic [WRAP_W-1:0] wraps,
    output logic [ERRC_W-1:0] err_total,
    output logic [1:0]        state
);

    state_e            state_r, state_nxt_s;
    logic [WIDTH-1:0]  prev_r;
    logic [3:0]        err_run_r;
    logic              locked_r, err_r, fault_r;
    logic              prev_ld_s, wrap_inc_s, err_inc_s, run_clr_s;
    logic              locked_nxt_s, fault_nxt_s;
    logic              match_s, prev_ones_s, at_limit_s;

    assign match_s     = (q_in == (prev_r + WIDTH'(1)));
    assign prev_ones_s = (prev_r == {WIDTH{1'b1}});
    assign at_limit_s  = (({1'b0, err_run_r} + 5'd1) == 5'(ERR_LIMIT));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath strobes; clr_err drops any same-edge sample.
    always_comb begin
        state_nxt_s = state_r;
        prev_ld_s   = 1'b0;
        wrap_inc_s  = 1'b0;
        err_inc_s   = 1'b0;
        run_clr_s   = 1'b0;
        if (clr_err) begin
            state_nxt_s = IDLE;
        end else if (en) begin
            case (state_r)
                IDLE: begin
                    prev_ld_s   = 1'b1;
                    state_nxt_s = ACQUIRE;
                end
                ACQUIRE: begin
                    prev_ld_s = 1'b1;
                    if (match_s) begin
                        state_nxt_s = TRACK;
                        wrap_inc_s  = prev_ones_s;
                    end else begin
                        state_nxt_s = ACQUIRE;
                    end
                end
                TRACK: begin
                    prev_ld_s = 1'b1;
                    if (match_s) begin
                        wrap_inc_s = prev_ones_s;
                        run_clr_s  = 1'b1;
                    end else begin
                        err_inc_s = 1'b1;
                        if (at_limit_s) begin
                            state_nxt_s = FAULT;
                        end else begin
                            state_nxt_s = TRACK;
                        end
                    end
                end
                FAULT: begin
                    state_nxt_s = FAULT;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output decode from the next state, registered below.
    always_comb begin
        locked_nxt_s = (state_nxt_s == TRACK);
        fault_nxt_s  = (state_nxt_s == FAULT);
    end

    // Registered outputs, last sample and consecutive-error run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r    <= '0;
            err_run_r <= 4'd0;
            locked_r  <= 1'b0;
            err_r     <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            locked_r <= locked_nxt_s;
            fault_r  <= fault_nxt_s;
            err_r    <= err_inc_s;
            if (prev_ld_s) begin
                prev_r <= q_in;
            end else begin
                prev_r <= prev_r;
            end
            if (clr_err || run_clr_s) begin
                err_run_r <= 4'd0;
            end else if (err_inc_s) begin
                err_run_r <= err_run_r + 4'd1;
            end else begin
                err_run_r <= err_run_r;
            end
        end
    end

    sat_counter #(.W(WRAP_W)) u_wraps (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_err),
        .inc   (wrap_inc_s),
        .count (wraps)
    );

    sat_counter #(.W(ERRC_W)) u_err_total (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_err),
        .inc   (err_inc_s),
        .count (err_total)
    );

    assign locked = locked_r;
    assign err    = err_r;
    assign fault  = fault_r;
    assign state  = state_r;

endmodule

// File: tb/tb_count_monitor.sv
// Directed table-driven bench for count_monitor plus a narrow-wrap instance.
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, clr_err, en2, clr2;
    logic [3:0] q_in, q2;
    logic       locked, err, fault, locked2, err2, fault2;
    logic [7:0] wraps, err_total, err_total2;
    logic [1:0] wraps2;
    logic [1:0] state, state2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    count_monitor dut (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in), .clr_err(clr_err),
        .locked(locked), .err(err), .fault(fault), .wraps(wraps),
        .err_total(err_total), .state(state)
    );

    count_monitor #(.WRAP_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .q_in(q2), .clr_err(clr2),
        .locked(locked2), .err(err2), .fault(fault2), .wraps(wraps2),
        .err_total(err_total2), .state(state2)
    );

    typedef struct {
        logic       en;
        logic [3:0] q;
        logic       clr;
        logic       locked;
        logic       err;
        logic       fault;
        logic [1:0] st;
        logic [7:0] wraps;
        logic [7:0] errt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic [3:0] q, input logic c,
                       input logic lk, input logic er, input logic fl,
                       input logic [1:0] st, input logic [7:0] wr, input logic [7:0] et);
        vec_t v;
        v.en = e; v.q = q; v.clr = c; v.locked = lk; v.err = er; v.fault = fl;
        v.st = st; v.wraps = wr; v.errt = et;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [3:0] q, input logic c);
        en = e; q_in = q; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic e, input logic [3:0] q, input logic c);
        en2 = e; q2 = q; clr2 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic lk, input logic er,
                              input logic fl, input logic [1:0] st,
                              input logic [7:0] wr, input logic [7:0] et);
        check({tag, ".locked"}, int'(locked), int'(lk));
        check({tag, ".err"}, int'(err), int'(er));
        check({tag, ".fault"}, int'(fault), int'(fl));
        check({tag, ".state"}, int'(state), int'(st));
        check({tag, ".wraps"}, int'(wraps), int'(wr));
        check({tag, ".err_total"}, int'(err_total), int'(et));
    endtask

    initial begin
        // Clean count 0..15,0,1: lock on the second sample, one wrap.
        for (int i = 0; i < 16; i++) begin
            add(1'b1, 4'(i), 1'b0, (i > 0), 1'b0, 1'b0, (i == 0) ? 2'd1 : 2'd2, 8'd0, 8'd0);
        end
        add(1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd1, 8'd0);
        add(1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd1, 8'd0);
        // Single glitch: 0,1,2 then 4,5,6.
        add(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
        add(1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0, 8'd0);
        add(1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, 8'd0);
        add(1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, 8'd0);
        add(1'b1, 4'd4,  1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'd0, 8'd1);
        add(1'b1, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, 8'd1);
        add(1'b1, 4'd6,  1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, 8'd1);
        add(1'b0, 4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, 8'd1);
        // Three consecutive errors: 0,1 then 3,7,2 reach FAULT.
        add(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
        add(1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0, 8'd0);
        add(1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, 8'd0);
        add(1'b1, 4'd3,  1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'd0, 8'd1);
        add(1'b1, 4'd7,  1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'd0, 8'd2);
        add(1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 8'd0, 8'd3);
        add(1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'd0, 8'd3);
        add(1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'd0, 8'd3);
        add(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
        // Noisy acquire: 5,9,10,11.
        add(1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0, 8'd0);
        add(1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0, 8'd0);
        add(1'b1, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, 8'd0);
        add(1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, 8'd0);

        rst = 1'b1; en = 1'b0; q_in = 4'd0; clr_err = 1'b0;
        en2 = 1'b0; q2 = 4'd0; clr2 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_main("reset", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].q, vecs[i].clr);
            check_main($sformatf("vec%0d", i), vecs[i].locked, vecs[i].err,
                       vecs[i].fault, vecs[i].st, vecs[i].wraps, vecs[i].errt);
        end

        // Async reset while tracking at 7 with a wrap recorded.
        step(1'b0, 4'd0, 1'b1);
        step(1'b1, 4'd15, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        for (int v = 1; v <= 7; v++) begin
            step(1'b1, 4'(v), 1'b0);
        end
        check_main("pre_rst", 1'b1, 1'b0, 1'b0, 2'd2, 8'd1, 8'd0);
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_main("async_rst", 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
        #1 rst = 1'b0;
        step(1'b1, 4'd8, 1'b0);
        check_main("post_rst", 1'b0, 1'b0, 1'b0, 2'd1, 8'd0, 8'd0);
        step(1'b0, 4'd0, 1'b0);

        // Narrow wrap counter saturates at 3 after five wraps.
        for (int c = 0; c < 5; c++) begin
            for (int v = 0; v < 16; v++) begin
                step2(1'b1, 4'(v), 1'b0);
            end
        end
        check("sat.wraps4", int'(wraps2), 3);
        step2(1'b1, 4'd0, 1'b0);
        check("sat.wraps5", int'(wraps2), 3);
        check("sat.locked", int'(locked2), 1);
        step2(1'b1, 4'd1, 1'b1);
        check("clrwin.state", int'(state2), 0);
        check("clrwin.wraps", int'(wraps2), 0);
        check("clrwin.locked", int'(locked2), 0);
        step2(1'b1, 4'd2, 1'b0);
        check("clrwin.next_state", int'(state2), 1);
        check("clrwin.next_locked", int'(locked2), 0);
        step2(1'b0, 4'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
